sync_fifo_fwft: RTL and testbench

- Parametrised synchronous FIFO with first-word-fall-through output and valid/ready handshakes on both sides.
- Built around an internal dual-port array with a registered read port. That read register is the FIFO output stage.
- Adds fill count, programmable almost-full/almost-empty flags, synchronous flush, and sticky overflow/underflow error flags.
- Sits between producer and consumer pipelines in the same clock domain.

---
 rtl/sync_fifo_fwft_if.sv | 43 ++++
 rtl/sync_fifo_fwft.sv | 133 +++++++++++++
 tb/tb_sync_fifo_fwft.sv | 334 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sync_fifo_fwft_if.sv
// Valid/ready handshake bundle for both sides of sync_fifo_fwft.
// The parity sidebands exist only when SYNC_FIFO_PARITY_EN is defined.
interface sync_fifo_fwft_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
`ifdef SYNC_FIFO_PARITY_EN
  logic                  inj_parity_err;
  logic                  out_parity_err;
`endif

  // The FIFO is the slave on both handshakes; the environment is the master.
  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
`ifdef SYNC_FIFO_PARITY_EN
    input  inj_parity_err,
    output out_parity_err,
`endif
    output in_ready,
    output out_valid,
    output out_data
  );

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
`ifdef SYNC_FIFO_PARITY_EN
    output inj_parity_err,
    input  out_parity_err,
`endif
    input  in_ready,
    input  out_valid,
    input  out_data
  );
endinterface

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through synchronous FIFO whose array read register is the output stage.
// Defining SYNC_FIFO_PARITY_EN stores an even-parity bit per word and reports mismatches.
module sync_fifo_fwft #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 5,
  parameter int AF_LEVEL   = 2**ADDR_WIDTH - 2,
  parameter int AE_LEVEL   = 2
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                flush,
  input  logic                err_clear,
  sync_fifo_fwft_if.slave     bus,
  output logic [ADDR_WIDTH:0] count,
  output logic                almost_full,
  output logic                almost_empty,
  output logic                overflow,
  output logic                underflow
);

  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam int PTR_W = ADDR_WIDTH + 1;
`ifdef SYNC_FIFO_PARITY_EN
  localparam int WORD_W = DATA_WIDTH + 1;
`else
  localparam int WORD_W = DATA_WIDTH;
`endif
  localparam logic [PTR_W-1:0] DEPTH_CNT = PTR_W'(DEPTH);
  localparam logic [PTR_W-1:0] AF_CNT    = PTR_W'(AF_LEVEL);
  localparam logic [PTR_W-1:0] AE_CNT    = PTR_W'(AE_LEVEL);
  localparam logic [PTR_W-1:0] ONE       = PTR_W'(1);

  logic [WORD_W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic                  out_valid_q;
  logic [DATA_WIDTH-1:0] out_data_q;
  logic                  in_ready_c;
  logic                  push;
  logic                  pop;
  logic                  arr_nonempty;
  logic                  rd_issue;
  logic                  ovf_event;
  logic                  unf_event;
  logic [WORD_W-1:0]     wr_word;
  logic [WORD_W-1:0]     rd_word;

  assign in_ready_c   = count < DEPTH_CNT;
  assign push         = bus.in_valid & in_ready_c;
  assign pop          = out_valid_q & bus.out_ready;
  assign arr_nonempty = wr_ptr != rd_ptr;
  // The output stage refills whenever it is empty or being drained this cycle.
  assign rd_issue     = arr_nonempty & (~out_valid_q | pop);
  assign ovf_event    = bus.in_valid & ~in_ready_c;
  assign unf_event    = bus.out_ready & ~out_valid_q;
  assign rd_word      = mem[rd_ptr[ADDR_WIDTH-1:0]];

`ifdef SYNC_FIFO_PARITY_EN
  assign wr_word = {(^bus.in_data) ^ bus.inj_parity_err, bus.in_data};
`else
  assign wr_word = bus.in_data;
`endif

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign almost_full   = count >= AF_CNT;
  assign almost_empty  = count <= AE_CNT;

  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wr_ptr[ADDR_WIDTH-1:0]] <= wr_word;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else if (flush) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + ONE;
      end
      if (rd_issue) begin
        out_data_q  <= rd_word[DATA_WIDTH-1:0];
        rd_ptr      <= rd_ptr + ONE;
        out_valid_q <= 1'b1;
      end else if (pop) begin
        out_valid_q <= 1'b0;
      end
      if (push && !pop) begin
        count <= count + ONE;
      end else if (!push && pop) begin
        count <= count - ONE;
      end
    end
  end

`ifdef SYNC_FIFO_PARITY_EN
  logic parity_q;

  // Parity of the stored word travels with out_data, so it also holds across a flush.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      parity_q <= 1'b0;
    end else if (!flush && rd_issue) begin
      parity_q <= ^rd_word;
    end
  end

  assign bus.out_parity_err = out_valid_q & parity_q;
`endif

  // A fresh error event outranks err_clear in the same cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= (overflow & ~err_clear) | ovf_event;
      underflow <= (underflow & ~err_clear) | unf_event;
    end
  end

endmodule

// File: tb/tb_sync_fifo_fwft.sv
// Directed and randomized checks of sync_fifo_fwft against a queue-based reference model.
// Define SYNC_FIFO_PARITY_EN to also exercise the parity sideband.
`timescale 1ns/1ps
module tb_sync_fifo_fwft;
  localparam int DW    = 8;
  localparam int AW    = 5;
  localparam int DEPTH = 32;
  localparam int AF    = DEPTH - 2;
  localparam int AE    = 2;

  typedef struct {
    logic [DW-1:0] d;
    logic          inj;
    int            t;
  } entry_t;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          flush = 1'b0;
  logic          err_clear = 1'b0;
  logic [AW:0]   count;
  logic          almost_full;
  logic          almost_empty;
  logic          overflow;
  logic          underflow;

  sync_fifo_fwft_if #(.DATA_WIDTH(DW)) bus ();

  sync_fifo_fwft #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .AF_LEVEL(AF),
    .AE_LEVEL(AE)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .flush(flush),
    .err_clear(err_clear),
    .bus(bus),
    .count(count),
    .almost_full(almost_full),
    .almost_empty(almost_empty),
    .overflow(overflow),
    .underflow(underflow)
  );

  always #5 clk = ~clk;

  // Reference model: the FIFO is an ordered queue; a word becomes visible one edge after its push.
  entry_t mq[$];
  int     edge_no = 0;
  logic   m_ovf = 1'b0;
  logic   m_unf = 1'b0;
  int     total = 0;
  int     bad = 0;

  function automatic logic m_valid();
    return (mq.size() > 0) && (mq[0].t < edge_no);
  endfunction

  task automatic set_idle();
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
`ifdef SYNC_FIFO_PARITY_EN
    bus.inj_parity_err = 1'b0;
`endif
    flush     = 1'b0;
    err_clear = 1'b0;
  endtask

  // Advance one rising edge and update the model from the inputs presented at that edge.
  task automatic tick();
    logic   pre_valid, do_push, do_pop, ovf_ev, unf_ev;
    entry_t e;
    pre_valid = m_valid();
    do_push   = bus.in_valid && (mq.size() < DEPTH);
    do_pop    = pre_valid && bus.out_ready;
    ovf_ev    = bus.in_valid && (mq.size() == DEPTH);
    unf_ev    = bus.out_ready && !pre_valid;
    e.d       = bus.in_data;
    e.inj     = 1'b0;
`ifdef SYNC_FIFO_PARITY_EN
    e.inj     = bus.inj_parity_err;
`endif
    e.t       = edge_no + 1;
    @(posedge clk);
    edge_no++;
    m_ovf = (m_ovf && !err_clear) || ovf_ev;
    m_unf = (m_unf && !err_clear) || unf_ev;
    if (flush) begin
      mq.delete();
    end else begin
      if (do_pop) void'(mq.pop_front());
      if (do_push) mq.push_back(e);
    end
    #1;
  endtask

  task automatic test_reset();
    $display("[TB] test_reset");
    set_idle();
    rstn = 1'b0;
    #12;
    total++; if (count !== '0) begin bad++; $display("[TB] FAIL reset_count got=%0d exp=0", count); end
    total++; if ({bus.in_ready, almost_empty, almost_full} !== 3'b110) begin
      bad++; $display("[TB] FAIL reset_flags got=%b exp=110", {bus.in_ready, almost_empty, almost_full}); end
    total++; if ({bus.out_valid, overflow, underflow} !== 3'b000) begin
      bad++; $display("[TB] FAIL reset_valid_err got=%b exp=000", {bus.out_valid, overflow, underflow}); end
    total++; if (bus.out_data !== '0) begin bad++; $display("[TB] FAIL reset_data got=%0h exp=0", bus.out_data); end
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_latency();
    $display("[TB] test_latency");
    bus.in_valid = 1'b1; bus.in_data = 8'hA5;
    tick();
    bus.in_valid = 1'b0;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("[TB] FAIL lat_no_bypass got=%b exp=0", bus.out_valid); end
    total++; if (count !== 6'd1) begin bad++; $display("[TB] FAIL lat_count0 got=%0d exp=1", count); end
    tick();
    total++; if (bus.out_valid !== 1'b1 || bus.out_data !== 8'hA5) begin
      bad++; $display("[TB] FAIL lat_head got=%b/%0h exp=1/a5", bus.out_valid, bus.out_data); end
    total++; if (count !== 6'd1 || almost_empty !== 1'b1) begin
      bad++; $display("[TB] FAIL lat_count1 got=%0d/%b exp=1/1", count, almost_empty); end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    total++; if (count !== 6'd0 || bus.out_valid !== 1'b0) begin
      bad++; $display("[TB] FAIL lat_drain got=%0d/%b exp=0/0", count, bus.out_valid); end
  endtask

  task automatic test_full_overflow();
    $display("[TB] test_full_overflow");
    for (int i = 0; i < DEPTH; i++) begin
      bus.in_valid = 1'b1; bus.in_data = DW'(i);
      tick();
    end
    bus.in_valid = 1'b0;
    total++; if (count !== 6'd32 || bus.in_ready !== 1'b0) begin
      bad++; $display("[TB] FAIL full_count got=%0d/%b exp=32/0", count, bus.in_ready); end
    total++; if (almost_full !== 1'b1 || almost_empty !== 1'b0) begin
      bad++; $display("[TB] FAIL full_flags got=%b%b exp=10", almost_full, almost_empty); end
    bus.in_valid = 1'b1; bus.in_data = 8'hEE;
    tick();
    bus.in_valid = 1'b0;
    total++; if (overflow !== 1'b1 || count !== 6'd32 || bus.out_data !== 8'h00) begin
      bad++; $display("[TB] FAIL ovf_set got=%b/%0d/%0h exp=1/32/0", overflow, count, bus.out_data); end
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    total++; if (overflow !== 1'b0) begin bad++; $display("[TB] FAIL ovf_clear got=%b exp=0", overflow); end
    bus.in_valid = 1'b1; bus.in_data = 8'hDD; bus.out_ready = 1'b1;
    tick();
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    total++; if (count !== 6'd31 || overflow !== 1'b1 || bus.out_data !== 8'h01) begin
      bad++; $display("[TB] FAIL full_pushpop got=%0d/%b/%0h exp=31/1/1", count, overflow, bus.out_data); end
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 1; i < DEPTH; i++) begin
      total++; if (bus.out_valid !== 1'b1 || bus.out_data !== DW'(i)) begin
        bad++; $display("[TB] FAIL drain_%0d got=%b/%0h exp=1/%0h", i, bus.out_valid, bus.out_data, i); end
      tick();
    end
    bus.out_ready = 1'b0;
    total++; if (count !== 6'd0 || bus.out_valid !== 1'b0 || underflow !== 1'b0) begin
      bad++; $display("[TB] FAIL drain_end got=%0d/%b/%b exp=0/0/0", count, bus.out_valid, underflow); end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] exp_d;
    $display("[TB] test_back_to_back");
    for (int i = 0; i < 100; i++) begin
      bus.in_valid = 1'b1; bus.in_data = DW'(8'h40 + i); bus.out_ready = (i >= 2);
      tick();
      if (i >= 1) begin
        exp_d = DW'(8'h40 + i - 1);
        total++; if (bus.out_valid !== 1'b1 || bus.out_data !== exp_d || count !== 6'd2) begin
          bad++; $display("[TB] FAIL b2b_%0d got=%b/%0h/%0d exp=1/%0h/2", i, bus.out_valid, bus.out_data, count, exp_d); end
      end
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    tick();
    total++; if (bus.out_data !== 8'hA3 || count !== 6'd1) begin
      bad++; $display("[TB] FAIL b2b_tail got=%0h/%0d exp=a3/1", bus.out_data, count); end
    tick();
    bus.out_ready = 1'b0;
    total++; if (count !== 6'd0 || bus.out_valid !== 1'b0 || underflow !== 1'b0) begin
      bad++; $display("[TB] FAIL b2b_end got=%0d/%b/%b exp=0/0/0", count, bus.out_valid, underflow); end
  endtask

  task automatic test_underflow();
    $display("[TB] test_underflow");
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    total++; if (underflow !== 1'b1 || count !== 6'd0) begin
      bad++; $display("[TB] FAIL unf_set got=%b/%0d exp=1/0", underflow, count); end
    err_clear = 1'b1;
    tick();
    total++; if (underflow !== 1'b0) begin bad++; $display("[TB] FAIL unf_clear got=%b exp=0", underflow); end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    total++; if (underflow !== 1'b1) begin bad++; $display("[TB] FAIL unf_wins got=%b exp=1", underflow); end
    tick();
    err_clear = 1'b0;
    total++; if (underflow !== 1'b0) begin bad++; $display("[TB] FAIL unf_clear2 got=%b exp=0", underflow); end
  endtask

  task automatic test_flush();
    $display("[TB] test_flush");
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = 1'b1; bus.in_data = DW'(8'h80 + i);
      tick();
    end
    total++; if (count !== 6'd10) begin bad++; $display("[TB] FAIL flush_pre got=%0d exp=10", count); end
    flush = 1'b1; bus.in_data = 8'h77; bus.out_ready = 1'b1;
    tick();
    flush = 1'b0; bus.out_ready = 1'b0;
    total++; if (count !== 6'd0 || bus.out_valid !== 1'b0 || bus.out_data !== 8'h80) begin
      bad++; $display("[TB] FAIL flush_clr got=%0d/%b/%0h exp=0/0/80", count, bus.out_valid, bus.out_data); end
    bus.in_data = 8'h3C;
    tick();
    bus.in_valid = 1'b0;
    tick();
    total++; if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h3C || count !== 6'd1) begin
      bad++; $display("[TB] FAIL flush_next got=%b/%0h/%0d exp=1/3c/1", bus.out_valid, bus.out_data, count); end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

`ifdef SYNC_FIFO_PARITY_EN
  task automatic test_parity();
    $display("[TB] test_parity");
    bus.in_valid = 1'b1; bus.in_data = 8'h01; bus.inj_parity_err = 1'b1;
    tick();
    bus.in_data = 8'h02; bus.inj_parity_err = 1'b0;
    tick();
    bus.in_valid = 1'b0;
    total++; if (bus.out_data !== 8'h01 || bus.out_parity_err !== 1'b1) begin
      bad++; $display("[TB] FAIL par_bad got=%0h/%b exp=01/1", bus.out_data, bus.out_parity_err); end
    bus.out_ready = 1'b1;
    tick();
    total++; if (bus.out_data !== 8'h02 || bus.out_parity_err !== 1'b0) begin
      bad++; $display("[TB] FAIL par_good got=%0h/%b exp=02/0", bus.out_data, bus.out_parity_err); end
    tick();
    bus.out_ready = 1'b0;
  endtask
`endif

  task automatic test_random();
    logic [AW:0] ec;
    logic        ev;
    int          pv, pr;
    $display("[TB] test_random");
    for (int i = 0; i < 600; i++) begin
      pv = (i < 300) ? 80 : 35;
      pr = (i < 300) ? 30 : 75;
      bus.in_valid  = ($urandom_range(99) < pv);
      bus.in_data   = DW'($urandom);
      bus.out_ready = ($urandom_range(99) < pr);
      flush         = ($urandom_range(99) < 2);
      err_clear     = ($urandom_range(99) < 4);
`ifdef SYNC_FIFO_PARITY_EN
      bus.inj_parity_err = ($urandom_range(99) < 20);
`endif
      tick();
      ec = (AW+1)'(mq.size());
      ev = m_valid();
      total++; if (count !== ec) begin bad++; $display("[TB] FAIL rnd_count@%0d got=%0d exp=%0d", i, count, ec); end
      total++; if (bus.out_valid !== ev) begin bad++; $display("[TB] FAIL rnd_valid@%0d got=%b exp=%b", i, bus.out_valid, ev); end
      if (ev) begin
        total++; if (bus.out_data !== mq[0].d) begin
          bad++; $display("[TB] FAIL rnd_data@%0d got=%0h exp=%0h", i, bus.out_data, mq[0].d); end
`ifdef SYNC_FIFO_PARITY_EN
        total++; if (bus.out_parity_err !== mq[0].inj) begin
          bad++; $display("[TB] FAIL rnd_par@%0d got=%b exp=%b", i, bus.out_parity_err, mq[0].inj); end
`endif
      end
      total++; if ({bus.in_ready, almost_full, almost_empty} !== {ec < DEPTH, ec >= AF, ec <= AE}) begin
        bad++; $display("[TB] FAIL rnd_flags@%0d got=%b exp=%b", i, {bus.in_ready, almost_full, almost_empty},
                        {ec < DEPTH, ec >= AF, ec <= AE}); end
      total++; if ({overflow, underflow} !== {m_ovf, m_unf}) begin
        bad++; $display("[TB] FAIL rnd_err@%0d got=%b%b exp=%b%b", i, overflow, underflow, m_ovf, m_unf); end
    end
    set_idle();
  endtask

  task automatic test_async_reset();
    $display("[TB] test_async_reset");
    bus.in_valid = 1'b1; bus.in_data = 8'h5A;
    tick();
    tick();
    bus.in_valid = 1'b0;
    #2;
    rstn = 1'b0;
    #1;
    total++; if (count !== 6'd0 || bus.out_valid !== 1'b0) begin
      bad++; $display("[TB] FAIL async_rst got=%0d/%b exp=0/0", count, bus.out_valid); end
    mq.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_latency();
    test_full_overflow();
    test_back_to_back();
    test_underflow();
    test_flush();
`ifdef SYNC_FIFO_PARITY_EN
    test_parity();
`endif
    test_random();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
